bp_be_stride_prefetcher: RTL and testbench
==========================================

Name: bp_be_stride_prefetcher

Overview:
Consumes the stride-detection stream from the backend reference prediction table: stride valid pulses with PC and stride, plus discovery start/confirm events. Tracks a small table of confirmed striding load streams and issues prefetch virtual addresses to the L1 D$ prefetch port over a valid/ready handshake. Sits beside the RPT in bp_be_checker, on the receiving end of its stride interface.

Parameters:
streams_p, 4, number of tracked stream entries (power of 2, ≥2)
stride_width_p, 8, stride width; two's-complement signed byte stride
degree_p, 2, prefetches issued per armed stride hit (≥1)
page_offset_width_p, 12, prefetches never cross this page boundary
vaddr_width_p, from bp_params_p, virtual address width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
stride_v_i  in  1  stride report valid (1-cycle pulse)
stride_i  in  stride_width_p  detected stride, signed
pc_i  in  vaddr_width_p  PC of the striding load
eff_addr_i  in  vaddr_width_p  effective address of the reporting load
start_discovery_i  in  1  new discovery window begins
confirm_discovery_i  in  1  discovery window confirmed
prefetch_v_o  out  1  prefetch request valid
prefetch_addr_o  out  vaddr_width_p  prefetch virtual address
prefetch_ready_and_i  in  1  D$ accepts request
armed_o  out  1  FSM in e_armed

Behaviour:
- Reset (asserted low, async): all entries invalid, credits 0, RR pointers 0, FSM e_idle; prefetch_v_o=0, prefetch_addr_o=0, armed_o=0.
- Entry: {v, armed, pc, stride, next_addr, credit[clog2(degree_p+1)]}.
- FSM: e_idle --start_discovery_i--> e_discover; e_discover --confirm_discovery_i--> e_armed; e_armed --start_discovery_i--> e_discover. start takes priority if start and confirm arrive together. armed_o = (state==e_armed).
- start_discovery_i: clear armed and credit on every entry, same edge.
- confirm_discovery_i: set armed on every valid entry.
- stride_v_i, full-PC CAM lookup:
  - hit: stride←stride_i, next_addr←eff_addr_i + sext(stride_i); credit←degree_p if entry armed (after this cycle's start/confirm applied), else 0.
  - miss: allocate entry at alloc pointer (round-robin, increments per allocation, wraps at streams_p); armed = (FSM in e_armed and no start this cycle); credit 0.
  - stride_i==0: entry updated, credit forced 0.
- Issue: round-robin arbiter over entries with credit>0 loads a one-entry output register when empty or on a handshake. Handshake = prefetch_v_o & prefetch_ready_and_i. On load: winner next_addr←next_addr+sext(stride), credit−1.
- Page rule: if the next value of next_addr differs from the current in bits above page_offset_width_p, winner credit forced 0 (current address still issued).
- prefetch_v_o/prefetch_addr_o registered; addr held stable while v & ~ready; back-to-back issue on consecutive ready cycles.
- Latency: armed hit at edge N → prefetch_v_o high after edge N+1 at the earliest.
- Same-cycle stride hit and arbiter win on one entry: stride update wins, credit←degree_p, no decrement that cycle.
- Arithmetic modulo 2^vaddr_width_p; negative strides descend.
- Reset mid-operation: pending output request dropped immediately.

Test Plan:
- Reset → prefetch_v_o=0, armed_o=0; stride_v_i pc=0x100 stride=8 eff=0x1000 while e_idle → entry allocated, no prefetch.
- start, same stride report, confirm, report pc=0x100 eff=0x1008 stride=8, ready=1 → prefetches 0x1010 then 0x1018 on consecutive cycles, then prefetch_v_o=0.
- As above with ready=0 for 5 cycles → prefetch_addr_o holds 0x1010 with prefetch_v_o=1, then 0x1010, 0x1018 after ready rises.
- Armed, stride=-16 (0xF0), eff=0x2020 → prefetches 0x2010, 0x2000.
- Armed, stride=64, eff=0x1F80 → single prefetch 0x1FC0; 0x2000 suppressed by page rule.
- Armed, 5 distinct PCs reported → fifth allocation replaces entry 0; start_discovery_i mid-issue → credits cleared, no new loads after current handshake.

Source files
------------

// File: rtl/bp_be_stride_prefetcher_if.sv
// Stride-report stream from the reference prediction table plus the
// L1 D$ prefetch request port. The slave modport is the prefetcher's
// view; the master modport is the surrounding RPT / D$ side.
interface bp_be_stride_prefetcher_if #(
  parameter int stride_width_p = 8,
  parameter int vaddr_width_p  = 39
) ();

  // Stride detection stream
  logic                      stride_v_i;
  logic [stride_width_p-1:0] stride_i;
  logic [vaddr_width_p-1:0]  pc_i;
  logic [vaddr_width_p-1:0]  eff_addr_i;
  logic                      start_discovery_i;
  logic                      confirm_discovery_i;

  // Prefetch request port
  logic                      prefetch_v_o;
  logic [vaddr_width_p-1:0]  prefetch_addr_o;
  logic                      prefetch_ready_and_i;

  modport slave (
    input  stride_v_i,
    input  stride_i,
    input  pc_i,
    input  eff_addr_i,
    input  start_discovery_i,
    input  confirm_discovery_i,
    output prefetch_v_o,
    output prefetch_addr_o,
    input  prefetch_ready_and_i
  );

  modport master (
    output stride_v_i,
    output stride_i,
    output pc_i,
    output eff_addr_i,
    output start_discovery_i,
    output confirm_discovery_i,
    input  prefetch_v_o,
    input  prefetch_addr_o,
    output prefetch_ready_and_i
  );

endinterface

// File: rtl/bp_be_stride_prefetcher.sv
// Stride prefetcher: keeps a small table of striding load streams learned
// from the RPT stride reports, and once the discovery window is confirmed
// issues up to degree_p prefetch addresses per armed stride hit through a
// one-entry registered valid/ready output. Prefetches never cross a page.
module bp_be_stride_prefetcher #(
  parameter int streams_p           = 4,
  parameter int stride_width_p      = 8,
  parameter int degree_p            = 2,
  parameter int page_offset_width_p = 12,
  parameter int vaddr_width_p       = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_be_stride_prefetcher_if.slave pf_if,
  output logic                     armed_o
);

  localparam int idx_w_lp  = $clog2(streams_p);
  localparam int cred_w_lp = $clog2(degree_p + 1);

  localparam logic [1:0] E_IDLE     = 2'd0;
  localparam logic [1:0] E_DISCOVER = 2'd1;
  localparam logic [1:0] E_ARMED    = 2'd2;

  localparam logic [cred_w_lp-1:0] DEGREE_LP = cred_w_lp'(degree_p);

  // Sign-extend a byte stride to the address width
  function automatic logic [vaddr_width_p-1:0] sext_stride(
    input logic [stride_width_p-1:0] s
  );
    return {{(vaddr_width_p - stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  // Global state
  logic [1:0]               r_state;
  logic [idx_w_lp-1:0]      r_alloc_ptr;
  logic [idx_w_lp-1:0]      r_rr_ptr;
  logic                     r_pf_v;
  logic [vaddr_width_p-1:0] r_pf_addr;

  // Read-side views of the per-entry registers
  logic                      w_ent_v      [streams_p];
  logic [vaddr_width_p-1:0]  w_ent_pc     [streams_p];
  logic [stride_width_p-1:0] w_ent_stride [streams_p];
  logic [vaddr_width_p-1:0]  w_ent_next   [streams_p];
  logic [cred_w_lp-1:0]      w_ent_credit [streams_p];

  logic                     w_start;
  logic                     w_confirm;
  logic [vaddr_width_p-1:0] w_report_addr;
  logic                     w_hit;
  logic [idx_w_lp-1:0]      w_hit_idx;
  logic                     w_hit_v;
  logic                     w_alloc_v;
  logic                     w_alloc_armed;
  logic                     w_grant_v;
  logic [idx_w_lp-1:0]      w_grant_idx;
  logic [idx_w_lp-1:0]      w_cand;
  logic                     w_handshake;
  logic                     w_load;
  logic [vaddr_width_p-1:0] w_win_addr;
  logic [vaddr_width_p-1:0] w_win_next;
  logic                     w_win_cross;

  assign w_start       = pf_if.start_discovery_i;
  assign w_confirm     = pf_if.confirm_discovery_i;
  assign w_report_addr = pf_if.eff_addr_i + sext_stride(pf_if.stride_i);

  // Full-PC CAM lookup of the reporting load
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < streams_p; i++) begin
      if (!w_hit && w_ent_v[i] && (w_ent_pc[i] == pf_if.pc_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = idx_w_lp'(i);
      end
    end
  end

  assign w_hit_v       = pf_if.stride_v_i & w_hit;
  assign w_alloc_v     = pf_if.stride_v_i & ~w_hit;
  assign w_alloc_armed = (r_state == E_ARMED) & ~w_start;

  // Round-robin search for the first entry with credit, starting at r_rr_ptr
  always_comb begin
    w_grant_v   = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < streams_p; k++) begin
      w_cand = r_rr_ptr + idx_w_lp'(k);
      if (!w_grant_v && (w_ent_credit[w_cand] != '0)) begin
        w_grant_v   = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // The output register refills when empty or draining; a discovery restart
  // clears all credit on this same edge, so it also blocks a refill.
  assign w_handshake = r_pf_v & pf_if.prefetch_ready_and_i;
  assign w_load      = w_grant_v & ~w_start & (~r_pf_v | pf_if.prefetch_ready_and_i);
  assign w_win_addr  = w_ent_next[w_grant_idx];
  assign w_win_next  = w_win_addr + sext_stride(w_ent_stride[w_grant_idx]);
  assign w_win_cross = w_win_next[vaddr_width_p-1:page_offset_width_p]
                    != w_win_addr[vaddr_width_p-1:page_offset_width_p];

  for (genvar gi = 0; gi < streams_p; gi++) begin : g_ent
    logic                      r_v;
    logic                      r_armed;
    logic [vaddr_width_p-1:0]  r_pc;
    logic [stride_width_p-1:0] r_stride;
    logic [vaddr_width_p-1:0]  r_next_addr;
    logic [cred_w_lp-1:0]      r_credit;

    logic w_hit_me;
    logic w_alloc_me;
    logic w_win_me;
    logic w_armed_next;

    assign w_hit_me     = w_hit_v & (w_hit_idx == idx_w_lp'(gi));
    assign w_alloc_me   = w_alloc_v & (r_alloc_ptr == idx_w_lp'(gi));
    assign w_win_me     = w_load & (w_grant_idx == idx_w_lp'(gi));
    assign w_armed_next = w_start ? 1'b0 : ((w_confirm & r_v) ? 1'b1 : r_armed);

    // Entry update; allocation beats a stride hit, which beats the
    // discovery clear, which beats the issue-side credit decrement.
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        r_v         <= 1'b0;
        r_armed     <= 1'b0;
        r_pc        <= '0;
        r_stride    <= '0;
        r_next_addr <= '0;
        r_credit    <= '0;
      end else if (w_alloc_me) begin
        r_v         <= 1'b1;
        r_armed     <= w_alloc_armed;
        r_pc        <= pf_if.pc_i;
        r_stride    <= pf_if.stride_i;
        r_next_addr <= w_report_addr;
        r_credit    <= '0;
      end else begin
        r_armed <= w_armed_next;
        if (w_hit_me) begin
          r_stride    <= pf_if.stride_i;
          r_next_addr <= w_report_addr;
          r_credit    <= (w_armed_next && (pf_if.stride_i != '0)) ? DEGREE_LP : '0;
        end else if (w_start) begin
          r_credit <= '0;
        end else if (w_win_me) begin
          r_next_addr <= w_win_next;
          r_credit    <= w_win_cross ? '0 : (r_credit - cred_w_lp'(1));
        end
      end
    end

    assign w_ent_v[gi]      = r_v;
    assign w_ent_pc[gi]     = r_pc;
    assign w_ent_stride[gi] = r_stride;
    assign w_ent_next[gi]   = r_next_addr;
    assign w_ent_credit[gi] = r_credit;
  end

  // Discovery FSM; a start outranks a simultaneous confirm
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= E_IDLE;
    end else if (w_start) begin
      r_state <= E_DISCOVER;
    end else if (w_confirm && (r_state == E_DISCOVER)) begin
      r_state <= E_ARMED;
    end
  end

  // Round-robin allocation and arbitration pointers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_alloc_ptr <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_alloc_v) r_alloc_ptr <= r_alloc_ptr + idx_w_lp'(1);
      if (w_load)    r_rr_ptr    <= w_grant_idx + idx_w_lp'(1);
    end
  end

  // One-entry prefetch output register; address held while stalled
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_pf_v    <= 1'b0;
      r_pf_addr <= '0;
    end else if (w_load) begin
      r_pf_v    <= 1'b1;
      r_pf_addr <= w_win_addr;
    end else if (w_handshake) begin
      r_pf_v    <= 1'b0;
    end
  end

  assign pf_if.prefetch_v_o    = r_pf_v;
  assign pf_if.prefetch_addr_o = r_pf_addr;
  assign armed_o               = (r_state == E_ARMED);

endmodule

// File: tb/tb_bp_be_stride_prefetcher.sv
// Bench for the stride prefetcher: directed scenarios with literal expected
// prefetch sequences, then randomized traffic compared cycle by cycle with a
// behavioural stream-table model.
module tb_bp_be_stride_prefetcher;

  localparam int N   = 4;
  localparam int SW  = 8;
  localparam int DEG = 2;
  localparam int PG  = 12;
  localparam int VA  = 39;
  localparam longint unsigned MASK = (64'd1 << VA) - 64'd1;

  logic clk;
  logic rst_n;
  logic armed;

  bp_be_stride_prefetcher_if #(.stride_width_p(SW), .vaddr_width_p(VA)) pf_if ();

  bp_be_stride_prefetcher #(
    .streams_p(N), .stride_width_p(SW), .degree_p(DEG),
    .page_offset_width_p(PG), .vaddr_width_p(VA)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .pf_if   (pf_if),
    .armed_o (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              v;
    bit              armed;
    longint unsigned pc;
    longint          stride;
    longint unsigned next;
    int              credit;
  } ent_t;

  ent_t            m_e[N];
  int              m_mode;   // 0 idle, 1 discover, 2 armed
  int              m_alloc;
  int              m_rr;
  bit              m_pv;
  longint unsigned m_pa;
  longint unsigned acc_q[$];
  int              acc_cyc[$];
  int              cyc;
  int              n_checks;
  int              n_fail;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_e[i] = '{0, 0, 0, 0, 0, 0};
    m_mode = 0; m_alloc = 0; m_rr = 0; m_pv = 0; m_pa = 0;
  endtask

  // One clock edge of the stream table, from the behavioural rules
  task automatic model_step(bit st, bit cf, bit sv, longint sd,
                            longint unsigned pc, longint unsigned eff, bit rdy);
    int win = -1;
    int hit = -1;
    bit fired = m_pv && rdy;
    longint unsigned nn;
    if (fired) begin
      acc_q.push_back(m_pa);
      acc_cyc.push_back(cyc);
      $display("txn prefetch addr=0x%0h cycle=%0d", m_pa, cyc);
    end
    if (!st && (!m_pv || rdy)) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && m_e[(m_rr + k) % N].credit > 0) win = (m_rr + k) % N;
      end
    end
    if (win >= 0) begin
      m_pv = 1; m_pa = m_e[win].next; m_rr = (win + 1) % N;
    end else if (fired) begin
      m_pv = 0;
    end
    if (sv) begin
      for (int i = 0; i < N; i++)
        if (hit < 0 && m_e[i].v && m_e[i].pc == pc) hit = i;
    end
    for (int i = 0; i < N; i++) begin
      if (st) begin m_e[i].armed = 0; m_e[i].credit = 0; end
      else if (cf && m_e[i].v) m_e[i].armed = 1;
    end
    if (win >= 0) begin
      nn = (m_e[win].next + longint'(m_e[win].stride)) & MASK;
      m_e[win].credit = ((nn >> PG) != (m_e[win].next >> PG)) ? 0 : m_e[win].credit - 1;
      m_e[win].next = nn;
    end
    if (hit >= 0) begin
      m_e[hit].stride = sd;
      m_e[hit].next   = (eff + sd) & MASK;
      m_e[hit].credit = (m_e[hit].armed && sd != 0) ? DEG : 0;
    end else if (sv) begin
      m_e[m_alloc] = '{1, (m_mode == 2) && !st, pc, sd, (eff + sd) & MASK, 0};
      m_alloc = (m_alloc + 1) % N;
    end
    if (st) m_mode = 1;
    else if (cf && m_mode == 1) m_mode = 2;
  endtask

  task automatic compare();
    check_val("pf_v", pf_if.prefetch_v_o, m_pv);
    check_val("pf_addr", pf_if.prefetch_addr_o, m_pa);
    check_val("armed", armed, m_mode == 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(pf_if.start_discovery_i, pf_if.confirm_discovery_i, pf_if.stride_v_i,
               longint'($signed(pf_if.stride_i)), pf_if.pc_i, pf_if.eff_addr_i,
               pf_if.prefetch_ready_and_i);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic drive(bit st, bit cf, bit sv, longint unsigned pc,
                       logic [SW-1:0] sd, longint unsigned eff, bit rdy);
    pf_if.start_discovery_i    = st;
    pf_if.confirm_discovery_i  = cf;
    pf_if.stride_v_i           = sv;
    pf_if.pc_i                 = pc[VA-1:0];
    pf_if.stride_i             = sd;
    pf_if.eff_addr_i           = eff[VA-1:0];
    pf_if.prefetch_ready_and_i = rdy;
    step();
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) drive(0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic expect_acc(string tag, int n, longint unsigned e0, longint unsigned e1);
    check_val({tag, "_count"}, acc_q.size(), n);
    if (n >= 1 && acc_q.size() >= 1) check_val({tag, "_addr0"}, acc_q[0], e0);
    if (n >= 2 && acc_q.size() >= 2) begin
      check_val({tag, "_addr1"}, acc_q[1], e1);
      check_val({tag, "_b2b"}, acc_cyc[1] - acc_cyc[0], 1);
    end
    acc_q.delete();
    acc_cyc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned r_pc, r_eff;
    logic [SW-1:0]   r_sd;
    int              sel;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    pf_if.start_discovery_i = 0; pf_if.confirm_discovery_i = 0; pf_if.stride_v_i = 0;
    pf_if.pc_i = '0; pf_if.stride_i = '0; pf_if.eff_addr_i = '0;
    pf_if.prefetch_ready_and_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_v", pf_if.prefetch_v_o, 0);
    check_val("rst_addr", pf_if.prefetch_addr_o, 0);
    check_val("rst_armed", armed, 0);
    rst_n = 1'b1;

    // Report while idle: allocates, never prefetches
    drive(0, 0, 1, 'h100, 8, 'h1000, 1);
    idle(4, 1);
    expect_acc("idle_alloc", 0, 0, 0);

    // Discover, confirm, armed hit with ready high
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 'h100, 8, 'h1000, 1);
    drive(0, 1, 0, 0, 0, 0, 1);
    check_val("armed_after_confirm", armed, 1);
    acc_q.delete(); acc_cyc.delete();
    drive(0, 0, 1, 'h100, 8, 'h1008, 1);
    idle(4, 1);
    expect_acc("armed_hit", 2, 'h1010, 'h1018);
    check_val("armed_hit_drained", pf_if.prefetch_v_o, 0);

    // Back-pressure: address held while stalled
    drive(0, 0, 1, 'h100, 8, 'h1008, 0);
    idle(5, 0);
    check_val("stall_v", pf_if.prefetch_v_o, 1);
    check_val("stall_addr", pf_if.prefetch_addr_o, 'h1010);
    idle(4, 1);
    expect_acc("stall", 2, 'h1010, 'h1018);

    // Negative stride descends
    drive(0, 0, 1, 'h200, 8'hF0, 'h2020, 1);
    drive(0, 0, 1, 'h200, 8'hF0, 'h2020, 1);
    idle(4, 1);
    expect_acc("neg_stride", 2, 'h2010, 'h2000);

    // Page rule stops the second prefetch
    drive(0, 0, 1, 'h300, 8'h40, 'h1F80, 1);
    drive(0, 0, 1, 'h300, 8'h40, 'h1F80, 1);
    idle(4, 1);
    expect_acc("page", 1, 'h1FC0, 0);

    // Fifth distinct PC replaces entry 0, so PC 0x100 now misses
    drive(0, 0, 1, 'h400, 8, 'h4000, 1);
    drive(0, 0, 1, 'h500, 8, 'h5000, 1);
    acc_q.delete(); acc_cyc.delete();
    drive(0, 0, 1, 'h100, 8, 'h1008, 1);
    idle(4, 1);
    expect_acc("replace", 0, 0, 0);

    // Start mid-issue: current request completes, nothing further loads
    drive(0, 0, 1, 'h500, 8, 'h5000, 0);
    idle(1, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    idle(4, 1);
    expect_acc("start_mid", 1, 'h5008, 0);
    check_val("start_mid_armed", armed, 0);

    // Asynchronous reset drops a pending request at once
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 'h500, 8, 'h5000, 0);
    idle(2, 0);
    check_val("pre_reset_v", pf_if.prefetch_v_o, 1);
    #2 rst_n = 1'b0;
    #1 check_val("async_reset_v", pf_if.prefetch_v_o, 0);
    check_val("async_reset_armed", armed, 0);
    model_reset();
    acc_q.delete(); acc_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    compare();

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      r_pc = 64'h1000 + 64'h40 * $urandom_range(0, 5);
      sel  = $urandom_range(0, 5);
      case (sel)
        0: r_sd = 8'h00;
        1: r_sd = 8'h08;
        2: r_sd = 8'hF8;
        3: r_sd = 8'h40;
        4: r_sd = 8'hC0;
        default: r_sd = SW'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) r_eff = MASK - $urandom_range(0, 255);
      else r_eff = {$urandom_range(0, 3), 12'($urandom)};
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, r_pc, r_sd, r_eff, $urandom_range(0, 3) != 0);
    end
    acc_q.delete(); acc_cyc.delete();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
